// File: rtl/ai_unit_issue_arbiter_pkg.sv
// Shared AI-unit ISA constants and arbiter state encoding for the issue arbiter slice.
package ai_unit_issue_arbiter_pkg;

    localparam logic [6:0] OP_AI_CUSTOM = 7'b0001011;

    localparam logic [6:0] AI_MATMUL    = 7'h00;
    localparam logic [6:0] AI_CONV2D    = 7'h01;
    localparam logic [6:0] AI_RELU      = 7'h02;
    localparam logic [6:0] AI_SIGMOID   = 7'h03;
    localparam logic [6:0] AI_MAXPOOL   = 7'h04;
    localparam logic [6:0] AI_AVGPOOL   = 7'h05;
    localparam logic [6:0] AI_BATCHNORM = 7'h06;

    localparam logic [2:0] AI_INT32 = 3'b000;
    localparam logic [2:0] AI_FP32  = 3'b010;

    localparam int FLAG_INVALID_OP = 2;
    localparam int FLAG_MEM_FAULT  = 4;

    // Flags reported when the watchdog aborts an op: the invalid-op bit only.
    localparam logic [4:0] TIMEOUT_FLAGS = 5'(1 << FLAG_INVALID_OP);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXEC,
        ST_DRAIN
    } arb_state_e;

endpackage

// File: rtl/ai_unit_issue_arbiter_if.sv
// Requester issue/response bundle plus the AI unit instruction port seen by the arbiter.
interface ai_unit_issue_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int XLEN    = 64
);
    localparam int IDW = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]           req_valid;
    logic [NUM_REQ-1:0]           req_ready;
    logic [NUM_REQ-1:0][6:0]      req_funct7;
    logic [NUM_REQ-1:0][2:0]      req_funct3;
    logic [NUM_REQ-1:0][XLEN-1:0] req_rs1_data;
    logic [NUM_REQ-1:0][XLEN-1:0] req_rs2_data;
    logic [NUM_REQ-1:0][XLEN-1:0] req_rs3_data;

    logic [NUM_REQ-1:0] rsp_valid;
    logic [XLEN-1:0]    rsp_result;
    logic [4:0]         rsp_flags;
    logic               rsp_timeout;
    logic               busy;
    logic [IDW-1:0]     owner_id;

    logic            ai_enable;
    logic [6:0]      ai_opcode;
    logic [6:0]      ai_funct7;
    logic [2:0]      ai_funct3;
    logic [XLEN-1:0] ai_rs1_data;
    logic [XLEN-1:0] ai_rs2_data;
    logic [XLEN-1:0] ai_rs3_data;
    logic            ai_ready;
    logic            ai_valid;
    logic [XLEN-1:0] ai_result;
    logic [4:0]      ai_flags;

    modport slave (
        input  req_valid, req_funct7, req_funct3, req_rs1_data, req_rs2_data, req_rs3_data,
        input  ai_ready, ai_valid, ai_result, ai_flags,
        output req_ready, rsp_valid, rsp_result, rsp_flags, rsp_timeout, busy, owner_id,
        output ai_enable, ai_opcode, ai_funct7, ai_funct3, ai_rs1_data, ai_rs2_data, ai_rs3_data
    );

    modport master (
        output req_valid, req_funct7, req_funct3, req_rs1_data, req_rs2_data, req_rs3_data,
        output ai_ready, ai_valid, ai_result, ai_flags,
        input  req_ready, rsp_valid, rsp_result, rsp_flags, rsp_timeout, busy, owner_id,
        input  ai_enable, ai_opcode, ai_funct7, ai_funct3, ai_rs1_data, ai_rs2_data, ai_rs3_data
    );

endinterface

// File: rtl/ai_unit_issue_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after the pointer, wrapping.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDW     = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDW-1:0]     ptr,
    output logic [NUM_REQ-1:0] grant_oh,
    output logic [IDW-1:0]     grant_idx,
    output logic               grant_any
);

    // NOTE: every output gets a default before the loop so no latch can be inferred.
    always_comb begin
        grant_oh  = '0;
        grant_idx = '0;
        grant_any = |req;
        // Scan from farthest to nearest so the closest candidate to ptr is written last.
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req[(int'(ptr) + k) % NUM_REQ]) begin
                grant_idx = IDW'((int'(ptr) + k) % NUM_REQ);
            end
        end
        grant_oh[grant_idx] = grant_any;
    end

endmodule

// File: rtl/ai_unit_issue_arbiter.sv
// Shares one AI unit between NUM_REQ requesters: round-robin grant, enable/valid sequencing,
// per-owner response pulse and a watchdog that aborts a hung operation.
module ai_unit_issue_arbiter
    import ai_unit_issue_arbiter_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int XLEN           = 64,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                    clk,
    input  logic                    rst_n,
    ai_unit_issue_arbiter_if.slave  bus
);

    localparam int             IDW      = $clog2(NUM_REQ);
    localparam int             CW       = $clog2(TIMEOUT_CYCLES);
    localparam logic [CW-1:0]  CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    arb_state_e        state, state_nxt;
    logic [IDW-1:0]    rr_ptr, owner;
    logic [CW-1:0]     wd_cnt;
    logic [NUM_REQ-1:0] grant_oh;
    logic [IDW-1:0]    grant_idx;
    logic              grant_any, grant_en, exec_done;

    logic [6:0]        op_funct7;
    logic [2:0]        op_funct3;
    logic [XLEN-1:0]   op_rs1, op_rs2, op_rs3;

    logic [NUM_REQ-1:0] rsp_valid_q;
    logic [XLEN-1:0]    rsp_result_q;
    logic [4:0]         rsp_flags_q;
    logic               rsp_timeout_q;

    rr_arbiter #(.NUM_REQ(NUM_REQ), .IDW(IDW)) u_rr (
        .req       (bus.req_valid),
        .ptr       (rr_ptr),
        .grant_oh  (grant_oh),
        .grant_idx (grant_idx),
        .grant_any (grant_any)
    );

    assign exec_done = (state == ST_EXEC) && (bus.ai_valid || (wd_cnt == CNT_LAST));

    always_comb begin
        state_nxt = state;
        grant_en  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (grant_any && bus.ai_ready) begin
                    grant_en  = 1'b1;
                    state_nxt = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (exec_done) state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                // The response pulse marks the first DRAIN cycle; leaving is allowed only after it.
                if (!(|rsp_valid_q) && bus.ai_ready) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            rr_ptr <= '0;
            owner  <= '0;
            wd_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (grant_en) begin
                owner  <= grant_idx;
                rr_ptr <= (grant_idx == IDW'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
                wd_cnt <= '0;
            end else if (state == ST_EXEC) begin
                wd_cnt <= wd_cnt + 1'b1;
            end
        end
    end

    // NOTE: operand and response registers drive ports directly, so they are reset to keep outputs at 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_funct7     <= '0;
            op_funct3     <= '0;
            op_rs1        <= '0;
            op_rs2        <= '0;
            op_rs3        <= '0;
            rsp_valid_q   <= '0;
            rsp_result_q  <= '0;
            rsp_flags_q   <= '0;
            rsp_timeout_q <= 1'b0;
        end else begin
            rsp_valid_q <= '0;
            if (grant_en) begin
                op_funct7 <= bus.req_funct7[grant_idx];
                op_funct3 <= bus.req_funct3[grant_idx];
                op_rs1    <= bus.req_rs1_data[grant_idx];
                op_rs2    <= bus.req_rs2_data[grant_idx];
                op_rs3    <= bus.req_rs3_data[grant_idx];
            end
            if (exec_done) begin
                rsp_valid_q[owner] <= 1'b1;
                // A result arriving on the expiry cycle still counts as a normal completion.
                if (bus.ai_valid) begin
                    rsp_result_q  <= bus.ai_result;
                    rsp_flags_q   <= bus.ai_flags;
                    rsp_timeout_q <= 1'b0;
                end else begin
                    rsp_result_q  <= '0;
                    rsp_flags_q   <= TIMEOUT_FLAGS;
                    rsp_timeout_q <= 1'b1;
                end
            end
        end
    end

    assign bus.req_ready   = grant_en ? grant_oh : '0;
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_result  = rsp_result_q;
    assign bus.rsp_flags   = rsp_flags_q;
    assign bus.rsp_timeout = rsp_timeout_q;
    assign bus.busy        = (state != ST_IDLE);
    assign bus.owner_id    = owner;

    assign bus.ai_enable   = (state == ST_EXEC);
    assign bus.ai_opcode   = OP_AI_CUSTOM;
    assign bus.ai_funct7   = op_funct7;
    assign bus.ai_funct3   = op_funct3;
    assign bus.ai_rs1_data = op_rs1;
    assign bus.ai_rs2_data = op_rs2;
    assign bus.ai_rs3_data = op_rs3;

endmodule

// File: tb/tb_ai_unit_issue_arbiter.sv
// Directed bench for ai_unit_issue_arbiter: a vector table of single transactions plus
// hand-written watchdog, ai_ready stall and mid-operation reset sequences.
module tb_ai_unit_issue_arbiter;
    import ai_unit_issue_arbiter_pkg::*;

    localparam int NR = 4;
    localparam int XL = 64;
    localparam int TO = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ai_unit_issue_arbiter_if #(.NUM_REQ(NR), .XLEN(XL)) bus ();

    ai_unit_issue_arbiter #(.NUM_REQ(NR), .XLEN(XL), .TIMEOUT_CYCLES(TO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fails  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // AI unit model: result after unit_lat enabled cycles (0 = never); records enable run length.
    int unit_lat    = 3;
    int en_cnt      = 0;
    int last_en_len = 0;

    always @(negedge clk) begin
        if (bus.ai_enable) begin
            en_cnt++;
            if (unit_lat != 0 && en_cnt == unit_lat) begin
                bus.ai_valid = 1'b1;
                if (bus.ai_funct7 == AI_RELU) begin
                    bus.ai_result = bus.ai_rs1_data[31] ? 64'h0 : bus.ai_rs1_data;
                    bus.ai_flags  = 5'b00000;
                end else if (bus.ai_funct7 <= AI_BATCHNORM) begin
                    bus.ai_result = bus.ai_rs1_data + bus.ai_rs2_data;
                    bus.ai_flags  = 5'b00000;
                end else begin
                    bus.ai_result = 64'h0;
                    bus.ai_flags  = 5'b00100;
                end
            end else begin
                bus.ai_valid = 1'b0;
            end
        end else begin
            if (en_cnt != 0) last_en_len = en_cnt;
            en_cnt       = 0;
            bus.ai_valid = 1'b0;
        end
    end

    typedef struct {
        logic [3:0]  mask;
        logic [6:0]  f7;
        logic [3:0]  exp_grant;
        logic [63:0] exp_res;
        logic [4:0]  exp_flags;
    } vec_t;

    vec_t vecs[13];

    task automatic set_f7(input logic [6:0] f7);
        for (int r = 0; r < NR; r++) bus.req_funct7[r] = f7;
    endtask

    // Called at/after a negedge; samples 1ns later each cycle until a grant appears.
    task automatic wait_grant(input string name, input logic [3:0] exp);
        logic [3:0] seen = '0;
        for (int i = 0; i < 40; i++) begin
            #1;
            if (bus.req_ready != 0) begin
                seen = bus.req_ready;
                break;
            end
            @(negedge clk);
        end
        check($sformatf("%s grant", name), 64'(seen), 64'(exp));
    endtask

    task automatic wait_rsp(input string name, input logic [3:0] exp_v, input logic [63:0] exp_res,
                            input logic [4:0] exp_flags, input logic exp_to);
        logic [3:0]  v   = '0;
        logic [63:0] res = 'x;
        logic [4:0]  fl  = 'x;
        logic        to  = 1'bx;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            #1;
            if (bus.rsp_valid != 0) begin
                v   = bus.rsp_valid;
                res = bus.rsp_result;
                fl  = bus.rsp_flags;
                to  = bus.rsp_timeout;
                break;
            end
        end
        check($sformatf("%s rsp_valid", name), 64'(v), 64'(exp_v));
        check($sformatf("%s rsp_result", name), res, exp_res);
        check($sformatf("%s rsp_flags", name), 64'(fl), 64'(exp_flags));
        check($sformatf("%s rsp_timeout", name), 64'(to), 64'(exp_to));
    endtask

    initial begin
        int stall_grants;

        vecs[0]  = '{4'b0001, AI_RELU,   4'b0001, 64'h0,          5'b00000};
        vecs[1]  = '{4'b1111, AI_MATMUL, 4'b0010, 64'h211,        5'b00000};
        vecs[2]  = '{4'b1111, AI_MATMUL, 4'b0100, 64'h312,        5'b00000};
        vecs[3]  = '{4'b1111, AI_MATMUL, 4'b1000, 64'h413,        5'b00000};
        vecs[4]  = '{4'b1111, AI_MATMUL, 4'b0001, 64'hC000_0100,  5'b00000};
        vecs[5]  = '{4'b1111, AI_MATMUL, 4'b0010, 64'h211,        5'b00000};
        vecs[6]  = '{4'b1111, AI_MATMUL, 4'b0100, 64'h312,        5'b00000};
        vecs[7]  = '{4'b1111, AI_MATMUL, 4'b1000, 64'h413,        5'b00000};
        vecs[8]  = '{4'b1111, AI_MATMUL, 4'b0001, 64'hC000_0100,  5'b00000};
        vecs[9]  = '{4'b0100, AI_MATMUL, 4'b0100, 64'h312,        5'b00000};
        vecs[10] = '{4'b0011, AI_MATMUL, 4'b0001, 64'hC000_0100,  5'b00000};
        vecs[11] = '{4'b1010, 7'h7F,     4'b0010, 64'h0,          5'b00100};
        vecs[12] = '{4'b0010, AI_RELU,   4'b0010, 64'h11,         5'b00000};

        bus.req_valid = '0;
        bus.ai_ready  = 1'b1;
        set_f7(AI_MATMUL);
        for (int r = 0; r < NR; r++) begin
            bus.req_funct3[r]   = AI_FP32;
            bus.req_rs2_data[r] = 64'h100 * 64'(r + 1);
            bus.req_rs3_data[r] = 64'h0;
        end
        bus.req_rs1_data[0] = 64'hC000_0000;
        bus.req_rs1_data[1] = 64'h11;
        bus.req_rs1_data[2] = 64'h12;
        bus.req_rs1_data[3] = 64'h13;

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        check("reset req_ready", 64'(bus.req_ready), 64'h0);
        check("reset rsp_valid", 64'(bus.rsp_valid), 64'h0);
        check("reset busy", 64'(bus.busy), 64'h0);
        check("reset ai_enable", 64'(bus.ai_enable), 64'h0);
        check("reset ai_opcode", 64'(bus.ai_opcode), 64'h0B);
        check("reset owner_id", 64'(bus.owner_id), 64'h0);
        check("reset rsp_result", bus.rsp_result, 64'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Table-driven transactions
        for (int i = 0; i < 13; i++) begin
            bus.req_valid = vecs[i].mask;
            set_f7(vecs[i].f7);
            wait_grant($sformatf("v%0d", i), vecs[i].exp_grant);
            wait_rsp($sformatf("v%0d", i), vecs[i].exp_grant, vecs[i].exp_res, vecs[i].exp_flags, 1'b0);
            check($sformatf("v%0d enable cycles", i), 64'(last_en_len), 64'd3);
        end
        bus.req_valid = '0;

        // Watchdog: unit never answers
        unit_lat      = 0;
        bus.req_valid = 4'b1000;
        set_f7(AI_MATMUL);
        wait_grant("timeout", 4'b1000);
        wait_rsp("timeout", 4'b1000, 64'h0, 5'b00100, 1'b1);
        check("timeout enable cycles", 64'(last_en_len), 64'(TO));
        check("timeout busy in drain", 64'(bus.busy), 64'h1);
        bus.req_valid = '0;
        unit_lat      = 3;
        repeat (3) @(negedge clk);
        #1;
        check("timeout back to idle", 64'(bus.busy), 64'h0);

        // ai_ready low blocks grants
        bus.ai_ready  = 1'b0;
        bus.req_valid = 4'b0001;
        stall_grants  = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            #1;
            if (bus.req_ready != 0) stall_grants++;
        end
        check("stall no grant", 64'(stall_grants), 64'h0);
        check("stall not busy", 64'(bus.busy), 64'h0);
        bus.ai_ready = 1'b1;
        wait_grant("stall release", 4'b0001);
        wait_rsp("stall release", 4'b0001, 64'hC000_0100, 5'b00000, 1'b0);
        bus.req_valid = '0;
        repeat (3) @(negedge clk);

        // Reset in the middle of EXEC
        bus.req_valid = 4'b0100;
        wait_grant("midreset", 4'b0100);
        repeat (2) @(negedge clk);
        #1;
        check("midreset enable before", 64'(bus.ai_enable), 64'h1);
        rst_n = 1'b0;
        #1;
        check("midreset ai_enable", 64'(bus.ai_enable), 64'h0);
        check("midreset rsp_valid", 64'(bus.rsp_valid), 64'h0);
        check("midreset busy", 64'(bus.busy), 64'h0);
        check("midreset owner_id", 64'(bus.owner_id), 64'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        wait_grant("regrant", 4'b0100);
        wait_rsp("regrant", 4'b0100, 64'h312, 5'b00000, 1'b0);
        check("regrant enable cycles", 64'(last_en_len), 64'd3);
        bus.req_valid = '0;

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
